// File: rtl/featuremap_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : featuremap_accumulator
//  Purpose  : Output stage of one conv feature map. It reduces the per-channel
//             3x3 results through a pipelined adder tree, adds the bias,
//             applies linear or leaky-ReLU activation and saturates.
//             It also supports ready/valid backpressure, frame-end marking
//             and a sticky saturation event counter.
//  Revision : 1.0  initial release
// ============================================================================
module featuremap_accumulator #(
  parameter int NUM_CH     = 32,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACT_MODE   = 1,
  parameter int IMG_SIZE   = 104
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic                         valid_in,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        bias,
  input  logic                         clr,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         last_out,
  output logic [15:0]                  sat_count
);

  localparam int c_lvls   = $clog2(NUM_CH);
  localparam int c_sum_w  = DATA_WIDTH + c_lvls;
  localparam int c_bias_w = c_sum_w + 1;
  localparam int c_prod_w = c_bias_w + 4;
  localparam int c_npix   = IMG_SIZE * IMG_SIZE;
  localparam int c_cnt_w  = (c_npix > 1) ? $clog2(c_npix) : 1;
  localparam logic [c_cnt_w-1:0] c_last_pix = c_cnt_w'(c_npix - 1);
  localparam logic signed [c_prod_w-1:0] c_max =
    {{(c_prod_w-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [c_prod_w-1:0] c_min =
    {{(c_prod_w-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Inputs, bias and output share one Q format, so the fraction position
  // never enters the arithmetic.
  logic w_unused_frac;
  assign w_unused_frac = (FRAC_BITS > 0);

  logic w_stall;
  logic w_adv;
  logic [c_lvls+1:0] vld_d, vld_q;

  assign valid_out = vld_q[c_lvls+1];
  assign w_stall   = valid_out && !ready_in;
  assign w_adv     = !w_stall;
  assign in_ready  = w_adv;

  // Adder tree: level k holds NUM_CH>>k sums of DATA_WIDTH+k bits.
  for (genvar k = 1; k <= c_lvls; k++) begin : g_lvl
    localparam int c_w = DATA_WIDTH + k;
    localparam int c_n = NUM_CH >> k;
    logic signed [c_w-1:0] node_d [c_n];
    logic signed [c_w-1:0] node_q [c_n];

    if (k == 1) begin : g_first
      // Pairwise sums of sign-extended channel inputs.
      always_comb begin
        for (int i = 0; i < c_n; i++) begin
          if (w_adv) begin
            node_d[i] = {data_in[(2*i+1)*DATA_WIDTH-1], data_in[2*i*DATA_WIDTH +: DATA_WIDTH]}
                      + {data_in[(2*i+2)*DATA_WIDTH-1], data_in[(2*i+1)*DATA_WIDTH +: DATA_WIDTH]};
          end else begin
            node_d[i] = node_q[i];
          end
        end
      end
    end else begin : g_next
      // Pairwise sums of the previous level, one bit wider to avoid overflow.
      always_comb begin
        for (int i = 0; i < c_n; i++) begin
          if (w_adv) begin
            node_d[i] = {g_lvl[k-1].node_q[2*i][c_w-2],   g_lvl[k-1].node_q[2*i]}
                      + {g_lvl[k-1].node_q[2*i+1][c_w-2], g_lvl[k-1].node_q[2*i+1]};
          end else begin
            node_d[i] = node_q[i];
          end
        end
      end
    end

    // Tree level register.
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        for (int i = 0; i < c_n; i++) node_q[i] <= '0;
      end else begin
        node_q <= node_d;
      end
    end
  end

  logic signed [c_sum_w-1:0]  w_tree_out;
  logic signed [c_bias_w-1:0] bsum_d, bsum_q;
  logic signed [c_prod_w-1:0] w_ext, w_prod, w_act;
  logic                       w_hi, w_lo;
  logic [DATA_WIDTH-1:0]      w_res;
  logic [DATA_WIDTH-1:0]      dout_d, dout_q;
  logic [15:0]                sat_d, sat_q;
  logic [c_cnt_w-1:0]         cnt_d, cnt_q;

  assign w_tree_out = g_lvl[c_lvls].node_q[0];

  // Bias add and activation/saturation datapath, plus the control next-state.
  always_comb begin
    bsum_d = bsum_q;
    if (w_adv) begin
      bsum_d = {w_tree_out[c_sum_w-1], w_tree_out}
             + {{(c_lvls+1){bias[DATA_WIDTH-1]}}, bias};
    end

    w_ext  = {{4{bsum_q[c_bias_w-1]}}, bsum_q};
    w_prod = w_ext * c_prod_w'(13);
    w_act  = (ACT_MODE == 1 && w_ext[c_prod_w-1]) ? (w_prod >>> 7) : w_ext;
    w_hi   = (w_act > c_max);
    w_lo   = (w_act < c_min);
    if (w_hi)      w_res = c_max[DATA_WIDTH-1:0];
    else if (w_lo) w_res = c_min[DATA_WIDTH-1:0];
    else           w_res = w_act[DATA_WIDTH-1:0];

    dout_d = w_adv ? w_res : dout_q;
    vld_d  = w_adv ? {vld_q[c_lvls:0], valid_in} : vld_q;

    sat_d = sat_q;
    if (clr) begin
      sat_d = '0;
    end else if (w_adv && vld_q[c_lvls] && (w_hi || w_lo) && sat_q != 16'hFFFF) begin
      sat_d = sat_q + 16'd1;
    end

    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (valid_out && ready_in) begin
      cnt_d = (cnt_q == c_last_pix) ? '0 : cnt_q + c_cnt_w'(1);
    end
  end

  // Bias, output, valid pipeline and counter registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bsum_q <= '0;
      dout_q <= '0;
      vld_q  <= '0;
      sat_q  <= '0;
      cnt_q  <= '0;
    end else begin
      bsum_q <= bsum_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      sat_q  <= sat_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_out  = dout_q;
  assign sat_count = sat_q;
  assign last_out  = valid_out && (cnt_q == c_last_pix);

endmodule
`default_nettype wire

// File: tb/tb_featuremap_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_featuremap_accumulator
//  Purpose  : Scoreboard bench for featuremap_accumulator. Two instances
//             (leaky and linear activation) share one stimulus stream; a
//             monitor pops expected results on every output transfer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_featuremap_accumulator;
  localparam int NCH  = 32;
  localparam int DW   = 16;
  localparam int IMG  = 4;
  localparam int NPIX = IMG * IMG;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [NCH*DW-1:0] data_in;
  logic              valid_in;
  logic [DW-1:0]     bias;
  logic              clr;
  logic              ready_in;
  logic [1:0]        in_ready, valid_out, last_out;
  logic [DW-1:0]     data_out [2];
  logic [15:0]       sat_count [2];

  always #5 Clk = ~Clk;

  // Instance 0 uses leaky ReLU, instance 1 is linear.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    featuremap_accumulator #(
      .NUM_CH(NCH), .DATA_WIDTH(DW), .FRAC_BITS(8),
      .ACT_MODE((g == 0) ? 1 : 0), .IMG_SIZE(IMG)
    ) u_dut (
      .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in),
      .in_ready(in_ready[g]), .bias(bias), .clr(clr),
      .data_out(data_out[g]), .valid_out(valid_out[g]), .ready_in(ready_in),
      .last_out(last_out[g]), .sat_count(sat_count[g])
    );
  end

  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  int          exp_sat [2];
  int          cnt_m [2];
  bit          stall_p [2];
  logic [15:0] prev_d [2];
  int          xfer_a;
  int          lasts [$];

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  // Reference: exact integer sum, activation by floor(13x/128), clamp.
  function automatic logic [16:0] model(input logic [NCH*DW-1:0] d, input logic [DW-1:0] b,
                                        input bit leaky);
    longint s = 0;
    for (int c = 0; c < NCH; c++) s += longint'($signed(d[c*DW +: DW]));
    s += longint'($signed(b));
    if (leaky && s < 0) s = (13 * s) >>> 7;
    if (s > 32767)  return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, s[15:0]};
  endfunction

  task automatic push_beat();
    logic [16:0] r0, r1;
    r0 = model(data_in, bias, 1'b1);
    r1 = model(data_in, bias, 1'b0);
    q0.push_back(r0[15:0]);
    q1.push_back(r1[15:0]);
    exp_sat[0] += int'(r0[16]);
    exp_sat[1] += int'(r1[16]);
  endtask

  task automatic rand_beat();
    bit big;
    big = ($urandom_range(0, 3) == 0);
    for (int c = 0; c < NCH; c++)
      data_in[c*DW +: DW] = big ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
  endtask

  function automatic bit rdy(input int cyc, input int mode);
    if (mode == 0) return 1'b1;
    if (cyc >= 10 && cyc <= 14) return 1'b0;
    if (cyc > 14 && (cyc % 3) == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int last_at(input int idx);
    return (lasts.size() > idx) ? lasts[idx] : -1;
  endfunction

  // Issue n random beats; optionally keep clocking until all results are out.
  task automatic stream(input int n, input int rmode, input int clr_at, input bit drain);
    int sent = 0;
    int cyc  = 0;
    bit have = 0;
    while ((sent < n || (drain && (q0.size() > 0 || q1.size() > 0))) && cyc < 2000) begin
      ready_in = rdy(cyc, rmode);
      clr      = (cyc == clr_at);
      if (sent < n) begin
        if (!have) begin rand_beat(); have = 1; end
        valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      @(negedge Clk);
      if (valid_in && in_ready[0]) begin push_beat(); sent++; have = 0; end
      @(posedge Clk); #1;
      cyc++;
    end
    valid_in = 1'b0; clr = 1'b0; ready_in = 1'b1;
    chk(cyc < 2000, "stream_timeout", cyc, 2000);
  endtask

  // One beat, measure latency and check against fixed expected values.
  task automatic directed(input logic [15:0] fill, input logic [15:0] ch0, input logic [15:0] b,
                          input logic [15:0] ea, input logic [15:0] eb, input string nm);
    int lat;
    for (int c = 0; c < NCH; c++) data_in[c*DW +: DW] = fill;
    data_in[15:0] = ch0;
    bias = b; ready_in = 1'b1; valid_in = 1'b1;
    @(negedge Clk);
    chk(in_ready[0] == 1'b1, {nm, "_accept"}, in_ready[0], 1);
    push_beat();
    @(posedge Clk); #1;
    valid_in = 1'b0;
    lat = 1;
    while (!valid_out[0] && lat < 20) begin @(posedge Clk); #1; lat++; end
    chk(lat == 7, {nm, "_latency"}, lat, 7);
    chk(data_out[0] == ea, {nm, "_leaky_out"}, data_out[0], ea);
    chk(data_out[1] == eb, {nm, "_linear_out"}, data_out[1], eb);
    @(posedge Clk); #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge Clk); #1;
    clr = 1'b0;
    exp_sat[0] = 0; exp_sat[1] = 0;
  endtask

  // Monitor: stall equation, hold during stall, frame marker, scoreboard pop.
  always @(negedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < 2; i++) begin cnt_m[i] = 0; stall_p[i] = 0; end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit xf;
        logic [15:0] e;
        chk(in_ready[i] == !(valid_out[i] && !ready_in), $sformatf("in_ready%0d", i),
            in_ready[i], !(valid_out[i] && !ready_in));
        if (stall_p[i])
          chk(valid_out[i] && data_out[i] == prev_d[i], $sformatf("stall_hold%0d", i),
              data_out[i], prev_d[i]);
        chk(last_out[i] == (valid_out[i] && cnt_m[i] == NPIX-1), $sformatf("last_out%0d", i),
            last_out[i], (valid_out[i] && cnt_m[i] == NPIX-1));
        xf = valid_out[i] && ready_in;
        if (xf) begin
          if (i == 0) begin
            xfer_a++;
            if (last_out[0]) lasts.push_back(xfer_a);
          end
          if (((i == 0) ? q0.size() : q1.size()) == 0) begin
            chk(1'b0, $sformatf("extra_out%0d", i), data_out[i], 0);
          end else begin
            if (i == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk(data_out[i] == e, $sformatf("data_out%0d", i), data_out[i], e);
          end
        end
        stall_p[i] = valid_out[i] && !ready_in;
        prev_d[i]  = data_out[i];
        if (clr)     cnt_m[i] = 0;
        else if (xf) cnt_m[i] = (cnt_m[i] == NPIX-1) ? 0 : cnt_m[i] + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    data_in = '0; bias = '0; valid_in = 1'b0; ready_in = 1'b1; clr = 1'b0;
    exp_sat[0] = 0; exp_sat[1] = 0; xfer_a = 0;
    Rst = 1'b1;
    #2 Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(data_out[i] == '0, "rst_data_out", data_out[i], 0);
      chk(valid_out[i] == 1'b0, "rst_valid_out", valid_out[i], 0);
      chk(last_out[i] == 1'b0, "rst_last_out", last_out[i], 0);
      chk(sat_count[i] == '0, "rst_sat_count", sat_count[i], 0);
      chk(in_ready[i] == 1'b1, "rst_in_ready", in_ready[i], 1);
    end
    Rst = 1'b1;
    @(posedge Clk); #1;

    directed(16'h0100, 16'h0100, 16'h0080, 16'h2080, 16'h2080, "sum");
    chk(sat_count[0] == 16'd0 && sat_count[1] == 16'd0, "sum_sat", sat_count[0], 0);
    directed(16'h0000, 16'hFF00, 16'h0000, 16'hFFE6, 16'hFF00, "neg");
    directed(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, "sat_pos");
    chk(sat_count[0] == 16'd1, "sat_pos_cnt0", sat_count[0], 1);
    chk(sat_count[1] == 16'd1, "sat_pos_cnt1", sat_count[1], 1);
    directed(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, "sat_neg");
    chk(sat_count[0] == 16'd2, "sat_neg_cnt0", sat_count[0], 2);
    chk(sat_count[1] == 16'd2, "sat_neg_cnt1", sat_count[1], 2);
    pulse_clr();
    chk(sat_count[0] == 16'd0, "clr_sat0", sat_count[0], 0);
    chk(sat_count[1] == 16'd0, "clr_sat1", sat_count[1], 0);

    // Frame marking with a continuous stream.
    xfer_a = 0; lasts.delete();
    bias = 16'($urandom_range(0, 511) - 256);
    stream(40, 0, -1, 1'b1);
    chk(lasts.size() == 2, "frame_last_count", lasts.size(), 2);
    chk(last_at(0) == 16, "frame_last_first", last_at(0), 16);
    chk(last_at(1) == 32, "frame_last_second", last_at(1), 32);

    // Clear lands on the cycle of transfer 20 and restarts the frame.
    pulse_clr();
    xfer_a = 0; lasts.delete();
    stream(40, 0, 26, 1'b1);
    chk(lasts.size() == 2, "clr_last_count", lasts.size(), 2);
    chk(last_at(0) == 16, "clr_last_first", last_at(0), 16);
    chk(last_at(1) == 36, "clr_last_second", last_at(1), 36);

    // Backpressure with random data; saturation counts must follow the model.
    pulse_clr();
    bias = 16'($urandom_range(0, 1023) - 512);
    stream(40, 1, -1, 1'b1);
    chk(sat_count[0] == 16'(exp_sat[0]), "bp_sat0", sat_count[0], exp_sat[0]);
    chk(sat_count[1] == 16'(exp_sat[1]), "bp_sat1", sat_count[1], exp_sat[1]);

    // Reset with the pipeline full.
    stream(7, 0, -1, 1'b0);
    chk(valid_out[0] == 1'b1, "prefill_valid", valid_out[0], 1);
    Rst = 1'b0;
    #1;
    chk(valid_out == 2'b00, "async_valid_drop", valid_out, 0);
    chk(in_ready == 2'b11, "async_in_ready", in_ready, 3);
    q0.delete(); q1.delete();
    exp_sat[0] = 0; exp_sat[1] = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk(sat_count[0] == 16'd0 && sat_count[1] == 16'd0, "rst_mid_sat", sat_count[0], 0);
    chk(valid_out == 2'b00, "rst_mid_valid", valid_out, 0);
    Rst = 1'b1;
    @(posedge Clk); #1;
    xfer_a = 0; lasts.delete();
    stream(3, 0, -1, 1'b1);
    chk(xfer_a == 3, "post_rst_transfers", xfer_a, 3);
    chk(lasts.size() == 0, "post_rst_no_last", lasts.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/featuremap_accumulator.md
# featuremap_accumulator

Parametrised feature-map output stage for a convolution layer. It takes the per-input-channel 3x3 convolution results for one output pixel and reduces them through a pipelined adder tree. It then adds the feature-map bias, applies the selected activation and saturates the result to the output width. The block sits directly after the bank of per-channel Conv2D3x3 instances and generalises the fixed 32-channel layer_N_featuremap_M structure:
- channel count, width, activation and image size are parameters;
- ready/valid backpressure, frame marking and a saturation counter are added.

## Interface
- NUM_CH, 32: input channels, power of two, 2..1024
- DATA_WIDTH, 16: signed fixed-point width of channel inputs, bias and output
- FRAC_BITS, 8: fractional bits; the same Q format applies to inputs, bias and output, so no rescaling occurs
- ACT_MODE, 1: 0 = linear, 1 = leaky ReLU with slope 13/128
- IMG_SIZE, 104: output feature-map side; frame = IMG_SIZE*IMG_SIZE pixels

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous reset, active-low
- data_in  in  NUM_CH*DATA_WIDTH  channel c in bits [c*DATA_WIDTH +: DATA_WIDTH], signed
- valid_in  in  1  data_in valid
- in_ready  out  1  block can accept a beat
- bias  in  DATA_WIDTH  signed bias; held stable by the controller for the whole frame
- clr  in  1  synchronous clear of pixel counter and sat_count
- data_out  out  DATA_WIDTH  signed result
- valid_out  out  1  data_out valid
- ready_in  in  1  downstream accepts
- last_out  out  1  qualifies the final pixel of a frame
- sat_count  out  16  saturation events, sticks at 0xFFFF

## Operation
- **Accept:** a beat is accepted when valid_in && in_ready.
- **Stall:**
  - stall = valid_out && !ready_in.
  - in_ready = !stall (combinational).
  - All pipeline stages, including bubbles, advance together when !stall and hold when stall.
- **Adder tree:**
  - L = log2(NUM_CH) registered stages.
  - Stage k holds NUM_CH/2^k partial sums, each DATA_WIDTH+k bits wide, sign-extended before every add.
  - No truncation occurs inside the tree.
- **Bias stage:** one registered stage. sum + sign-extended bias at width DATA_WIDTH+L+1.
- **Output stage:** one registered stage.
  - Activation:
    - ACT_MODE=1 and value negative: y = (13*x) >>> 7, arithmetic shift, i.e. floor.
    - Otherwise: y = x.
  - The product is computed at full width, DATA_WIDTH+L+5 bits.
  - Saturation: y clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- **sat_count:** increments by 1 whenever a valid beat is loaded into the output register with clamping applied. It stays at 0xFFFF once reached.
- **Pixel counter:**
  - Range 0..IMG_SIZE*IMG_SIZE-1.
  - Increments on each output transfer (valid_out && ready_in).
  - Wraps to 0 after transferring the beat with count = IMG_SIZE*IMG_SIZE-1.
- **last_out** = valid_out && (counter == IMG_SIZE*IMG_SIZE-1).
- **clr:**
  - Clears the counter and sat_count next edge.
  - Has priority over a simultaneous transfer and over a simultaneous saturation increment.
  - Does not flush the pipeline.
- **Bias change:** changing bias mid-frame affects beats that reach the bias stage after the change. The block does not check this.

## Timing
- **Latency:** L+2 cycles from acceptance to valid_out with no stall; 7 cycles for NUM_CH=32.
- **Throughput:** 1 beat/cycle while ready_in=1.
- **Stall behaviour:** data_out and valid_out are held stable while stall=1. No beat is lost or duplicated.
- **Reset values:** all valid bits 0, all data registers 0, data_out=0, valid_out=0, last_out=0, sat_count=0, pixel counter 0, in_ready=1.
- **Reset mid-operation:**
  - Rst low clears all stages asynchronously; in-flight beats are dropped.
  - valid_out falls without waiting for the clock.
  - After release, the first output is the first beat accepted post-reset, with pixel index 0.
- **Empty pipeline:** valid_out stays 0; ready_in is ignored.

## Test plan
- **Sum, linear:** NUM_CH=32, DATA_WIDTH=16, FRAC_BITS=8, ACT_MODE=0. All channels 0x0100, bias 0x0080 -> data_out 0x2080, valid_out exactly 7 cycles after acceptance, sat_count 0.
- **Leaky:** channel0=0xFF00, others 0, bias 0, ACT_MODE=1 -> data_out 0xFFE6 (-26). Same stimulus with ACT_MODE=0 -> 0xFF00.
- **Saturation:**
  - All channels 0x7FFF, bias 0x7FFF -> data_out 0x7FFF, sat_count 1.
  - Then all channels 0x8000, bias 0x8000 -> 0x8000, sat_count 2.
  - clr pulse -> sat_count 0.
- **Backpressure:**
  - Stream 40 random beats; drive ready_in low for cycles 10-14 and every third cycle afterwards.
  - Required: in_ready mirrors the stall equation; the output sequence equals the reference model in order, with none missing or duplicated.
  - data_out stays stable during stall.
- **Frame:**
  - IMG_SIZE=4, continuous stream of 40 beats -> last_out on transfers 16 and 32 only.
  - clr asserted on the cycle of transfer 20 -> next last_out on transfer 36.
- **Reset:** pipeline full with 7 beats in flight, Rst low for 2 cycles -> valid_out=0 asynchronously, sat_count=0, in_ready=1. The next 3 accepted beats emerge correctly; no stale data appears.
